decode_stage: RTL

//   Registered RV32 decode stage with a valid/ready handshake and a 2-entry skid buffer.

---
 rtl/decode_stage.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32 decode stage with valid/ready handshake and 2-entry skid buffer
// Decoding happens on the input side; outputs are driven straight from the head entry register.
module decode_stage #(
  parameter bit RV32E = 1'b0,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     insn,
  input  logic [PC_W-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [9:0]      cls,
  output logic [4:0]      rd_ptr,
  output logic [4:0]      rs1_ptr,
  output logic [4:0]      rs2_ptr,
  output logic [2:0]      fct3,
  output logic [6:0]      fct7,
  output logic [31:0]     imm,
  output logic            illegal
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [9:0]      cls;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      fct3;
    logic [6:0]      fct7;
    logic [31:0]     imm;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state;
  entry_t head, skid, dec;

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        known, use_rd, use_rs1, use_rs2, bad_reg;

  assign imm_i = {{20{insn[31]}}, insn[31:20]};
  assign imm_s = {{20{insn[31]}}, insn[31:25], insn[11:7]};
  assign imm_b = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
  assign imm_u = {insn[31:12], 12'b0};
  assign imm_j = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};

  always_comb begin
    dec     = '0;
    known   = 1'b1;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    dec.pc   = pc;
    dec.rd   = insn[11:7];
    dec.rs1  = insn[19:15];
    dec.rs2  = insn[24:20];
    dec.fct3 = insn[14:12];
    dec.fct7 = insn[31:25];
    case (insn[6:0])
      7'h37: begin dec.cls[0] = 1'b1; dec.imm = imm_u; use_rd = 1'b1; end
      7'h17: begin dec.cls[1] = 1'b1; dec.imm = imm_u; use_rd = 1'b1; end
      7'h6F: begin dec.cls[2] = 1'b1; dec.imm = imm_j; use_rd = 1'b1; end
      7'h67: begin dec.cls[3] = 1'b1; dec.imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1; end
      7'h63: begin dec.cls[4] = 1'b1; dec.imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'h03: begin dec.cls[5] = 1'b1; dec.imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1; end
      7'h23: begin dec.cls[6] = 1'b1; dec.imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'h13: begin dec.cls[7] = 1'b1; dec.imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1; end
      7'h33: begin dec.cls[8] = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'h73: begin dec.cls[9] = 1'b1; dec.imm = imm_i; end
      default: known = 1'b0;
    endcase
    // RV32E only has x0..x15, so bit 4 of any register field actually used is illegal.
    bad_reg = RV32E && ((use_rd && insn[11]) || (use_rs1 && insn[19]) || (use_rs2 && insn[24]));
    dec.illegal = !known || bad_reg;
    if (dec.illegal) begin
      dec.cls = '0;
      dec.imm = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      head      <= '0;
      skid      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            head      <= dec;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (in_valid && out_ready) begin
            head <= dec;
          end else if (in_valid) begin
            skid     <= dec;
            state    <= TWO;
            in_ready <= 1'b0;
          end else if (out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        TWO: begin
          // in_ready is low here, so only the pop side can move.
          if (out_ready) begin
            head     <= skid;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_pc  = head.pc;
  assign cls     = head.cls;
  assign rd_ptr  = head.rd;
  assign rs1_ptr = head.rs1;
  assign rs2_ptr = head.rs2;
  assign fct3    = head.fct3;
  assign fct7    = head.fct7;
  assign imm     = head.imm;
  assign illegal = head.illegal;

endmodule
